vending_transaction_ctrl: RTL and testbench

//  Top-level sequencer for the vending machine datapath.
//  - Accumulates inserted coin value and dispenses affordable items.
//  - Runs the inactivity timeout.
//  - Returns change one coin per cycle.
//  - Sits between the user-facing coin/item inputs and the dispense/return outputs.

---
 rtl/vending_transaction_ctrl_pkg.sv | 33 +++
 rtl/vending_transaction_ctrl_coin_change_selector.sv | 27 ++
 rtl/vending_transaction_ctrl.sv | 174 +++++++++++++++++
 tb/tb_vending_transaction_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_transaction_ctrl_pkg.sv
// Shared definitions for the vending transaction controller: sizes, limits,
// coin value / item price tables, FSM state encoding and a coin-sum helper.
package vending_transaction_ctrl_pkg;

  localparam int kNumCoins   = 3;
  localparam int kNumItems   = 4;
  localparam int kWaitTime   = 100;
  localparam int kMaxBalance = 10000;

  // Coin denominations, index 0 is the smallest; the change selector relies
  // on this ascending order to find the largest returnable coin.
  localparam logic [31:0] kCoinValue [kNumCoins] = '{32'd100, 32'd500, 32'd1000};

  // Item prices, index 0 is the cheapest.
  localparam logic [31:0] kItemPrice [kNumItems] = '{32'd400, 32'd500, 32'd1000, 32'd2000};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RETURN = 2'd2
  } state_t;

  // Total value of a multi-hot coin vector.
  function automatic logic [31:0] coin_sum(input logic [kNumCoins-1:0] coins);
    logic [31:0] sum;
    sum = '0;
    for (int i = 0; i < kNumCoins; i++) begin
      if (coins[i]) sum = sum + kCoinValue[i];
    end
    return sum;
  endfunction

endpackage

// File: rtl/vending_transaction_ctrl_coin_change_selector.sv
// Combinational change picker: returns the largest single coin whose value
// does not exceed the current balance, as a one-hot vector (zero when the
// balance is below the smallest coin).
module coin_change_selector
  import vending_transaction_ctrl_pkg::*;
(
  input  logic [31:0]          balance,
  output logic [kNumCoins-1:0] coin
);

  logic found;

  // Scan from the largest denomination down and keep the first that fits.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // otherwise paths that skip an assignment would infer a latch.
    coin  = '0;
    found = 1'b0;
    for (int i = kNumCoins - 1; i >= 0; i--) begin
      if (!found && (balance >= kCoinValue[i])) begin
        coin[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vending_transaction_ctrl.sv
// Vending machine transaction sequencer: accumulates coins, dispenses
// affordable items, runs the inactivity timer and pays change back one coin
// per cycle, largest denomination first.
module vending_transaction_ctrl
  import vending_transaction_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [kNumCoins-1:0] i_input_coin,
  input  logic [kNumItems-1:0] i_select_item,
  input  logic                 i_trigger_return,
  output logic [kNumItems-1:0] o_available_item,
  output logic [kNumItems-1:0] o_output_item,
  output logic [kNumCoins-1:0] o_return_coin,
  output logic [31:0]          o_current_total,
  output logic [31:0]          o_wait_time,
  output logic                 o_busy
);

  localparam logic [31:0] kWaitReload = 32'(kWaitTime);
  localparam logic [31:0] kBalanceMax = 32'(kMaxBalance);

  state_t                 state_q, state_d;
  logic [31:0]            balance_q, balance_d;
  logic [31:0]            wait_q, wait_d;
  logic [kNumItems-1:0]   item_q, item_d;
  logic [kNumCoins-1:0]   ret_q, ret_d;
  logic                   busy_q, busy_d;

  logic [31:0]            coin_total;
  logic                   coin_seen;
  logic                   coin_ok;
  logic                   pick_valid;
  logic [kNumItems-1:0]   pick_onehot;
  logic [31:0]            pick_price;
  logic [kNumCoins-1:0]   change_coin;
  logic [31:0]            change_value;
  logic [31:0]            active_balance;
  logic [31:0]            active_wait;

  // Change coin for the current balance; only used while returning.
  coin_change_selector u_change (
    .balance (balance_q),
    .coin    (change_coin)
  );

  assign change_value = coin_sum(change_coin);

  // Coin acceptance: the whole cycle's coins are taken or rejected together,
  // so the balance ceiling can never be crossed.
  always_comb begin
    coin_total = coin_sum(i_input_coin);
    coin_seen  = (i_input_coin != '0);
    coin_ok    = coin_seen && ((balance_q + coin_total) <= kBalanceMax);
  end

  // Item pick: lowest-index selected item affordable from the registered
  // (pre-coin) balance.
  always_comb begin
    pick_valid  = 1'b0;
    pick_onehot = '0;
    pick_price  = '0;
    for (int i = 0; i < kNumItems; i++) begin
      if (!pick_valid && i_select_item[i] && (kItemPrice[i] <= balance_q)) begin
        pick_valid     = 1'b1;
        pick_onehot[i] = 1'b1;
        pick_price     = kItemPrice[i];
      end
    end
  end

  // Balance and timer as they would be after an ACTIVE-state cycle.
  always_comb begin
    active_balance = balance_q
                   + (coin_ok    ? coin_total : 32'd0)
                   - (pick_valid ? pick_price : 32'd0);
    if (coin_ok || pick_valid) begin
      active_wait = kWaitReload;
    end else if (wait_q != 32'd0) begin
      active_wait = wait_q - 32'd1;
    end else begin
      active_wait = 32'd0;
    end
  end

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    state_d   = state_q;
    balance_d = balance_q;
    wait_d    = wait_q;
    item_d    = '0;
    ret_d     = '0;

    unique case (state_q)
      ST_IDLE: begin
        // Selects and return requests mean nothing with an empty balance.
        if (coin_ok) begin
          balance_d = balance_q + coin_total;
          wait_d    = kWaitReload;
          state_d   = ST_ACTIVE;
        end else if (coin_seen) begin
          ret_d = i_input_coin;
        end
      end

      ST_ACTIVE: begin
        if (coin_seen && !coin_ok) ret_d = i_input_coin;
        if (pick_valid) item_d = pick_onehot;
        balance_d = active_balance;
        if (active_balance == 32'd0) begin
          // Exact purchase: nothing to return, the transaction is over.
          wait_d  = 32'd0;
          state_d = ST_IDLE;
        end else begin
          wait_d = active_wait;
          if (i_trigger_return || (active_wait == 32'd0)) state_d = ST_RETURN;
        end
      end

      ST_RETURN: begin
        // Coins inserted now are never accepted; they ride back with the change.
        ret_d     = change_coin | i_input_coin;
        balance_d = balance_q - change_value;
        if ((balance_q - change_value) == 32'd0) begin
          wait_d  = 32'd0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        balance_d = '0;
        wait_d    = '0;
        state_d   = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_RETURN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    if (reset) begin
      state_q   <= ST_IDLE;
      balance_q <= '0;
      wait_q    <= '0;
      item_q    <= '0;
      ret_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      balance_q <= balance_d;
      wait_q    <= wait_d;
      item_q    <= item_d;
      ret_q     <= ret_d;
      busy_q    <= busy_d;
    end
  end

  // Affordability flags follow the registered balance directly.
  always_comb begin
    for (int i = 0; i < kNumItems; i++) begin
      o_available_item[i] = (balance_q >= kItemPrice[i]);
    end
  end

  assign o_output_item   = item_q;
  assign o_return_coin   = ret_q;
  assign o_current_total = balance_q;
  assign o_wait_time     = wait_q;
  assign o_busy          = busy_q;

endmodule

// File: tb/tb_vending_transaction_ctrl.sv
// Self-checking bench for vending_transaction_ctrl. Each test builds a table
// of per-cycle stimulus rows with the expected registered outputs; the
// expectation is queued when the row is driven and popped once the DUT has
// clocked it.
module tb_vending_transaction_ctrl;

  localparam logic [2:0] C100  = 3'b001;
  localparam logic [2:0] C500  = 3'b010;
  localparam logic [2:0] C1000 = 3'b100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  i_input_coin = '0;
  logic [3:0]  i_select_item = '0;
  logic        i_trigger_return = 1'b0;
  logic [3:0]  o_available_item;
  logic [3:0]  o_output_item;
  logic [2:0]  o_return_coin;
  logic [31:0] o_current_total;
  logic [31:0] o_wait_time;
  logic        o_busy;

  typedef struct packed {
    logic [3:0]  item;
    logic [2:0]  ret;
    logic [31:0] total;
    logic [31:0] wait_t;
    logic        busy;
    logic [3:0]  avail;
  } obs_t;

  typedef struct packed {
    logic       rst;
    logic [2:0] coin;
    logic [3:0] sel;
    logic       trig;
    obs_t       exp;
  } row_t;

  obs_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  vending_transaction_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .i_input_coin     (i_input_coin),
    .i_select_item    (i_select_item),
    .i_trigger_return (i_trigger_return),
    .o_available_item (o_available_item),
    .o_output_item    (o_output_item),
    .o_return_coin    (o_return_coin),
    .o_current_total  (o_current_total),
    .o_wait_time      (o_wait_time),
    .o_busy           (o_busy)
  );

  // Prices 400, 500, 1000, 2000.
  function automatic logic [3:0] avail_of(input logic [31:0] t);
    return {t >= 32'd2000, t >= 32'd1000, t >= 32'd500, t >= 32'd400};
  endfunction

  function automatic row_t mk(input logic rst, input logic [2:0] coin,
                              input logic [3:0] sel, input logic trig,
                              input logic [3:0] item, input logic [2:0] ret,
                              input int total, input int w, input logic busy);
    row_t r;
    r.rst        = rst;
    r.coin       = coin;
    r.sel        = sel;
    r.trig       = trig;
    r.exp.item   = item;
    r.exp.ret    = ret;
    r.exp.total  = 32'(total);
    r.exp.wait_t = 32'(w);
    r.exp.busy   = busy;
    r.exp.avail  = avail_of(32'(total));
    return r;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.item   = o_output_item;
    o.ret    = o_return_coin;
    o.total  = o_current_total;
    o.wait_t = o_wait_time;
    o.busy   = o_busy;
    o.avail  = o_available_item;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("item=%b ret=%b total=%0d wait=%0d busy=%b avail=%b",
                     o.item, o.ret, o.total, o.wait_t, o.busy, o.avail);
  endfunction

  // Drive one cycle of stimulus, queue its expectation, return #1 after the edge.
  task automatic apply(input row_t r);
    reset            = r.rst;
    i_input_coin     = r.coin;
    i_select_item    = r.sel;
    i_trigger_return = r.trig;
    exp_q.push_back(r.exp);
    @(posedge clk);
    #1;
    reset            = 1'b0;
    i_input_coin     = '0;
    i_select_item    = '0;
    i_trigger_return = 1'b0;
  endtask

  task automatic test_reset();
    row_t rows[$];
    obs_t got, e;
    rows.push_back(mk(1, C1000, 4'b1111, 1, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, C500,  4'b0000, 0, 0, 0, 0, 0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      got = observe(); e = exp_q.pop_front(); n_assert++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reset[%0d] got %s want %s", i, fmt(got), fmt(e));
      end
    end
  endtask

  task automatic test_purchase();
    row_t rows[$];
    obs_t got, e;
    rows.push_back(mk(0, C1000, 4'b0000, 0, 4'b0000, 3'b000, 1000, 100, 0));
    rows.push_back(mk(0, 0,     4'b0010, 0, 4'b0010, 3'b000,  500, 100, 0));
    rows.push_back(mk(0, 0,     4'b0000, 0, 4'b0000, 3'b000,  500,  99, 0));
    rows.push_back(mk(0, 0,     4'b0000, 1, 4'b0000, 3'b000,  500,  98, 1));
    rows.push_back(mk(0, 0,     4'b0000, 0, 4'b0000, 3'b010,    0,   0, 0));
    rows.push_back(mk(0, 0,     4'b0000, 0, 4'b0000, 3'b000,    0,   0, 0));
    rows.push_back(mk(0, 0,     4'b1111, 1, 4'b0000, 3'b000,    0,   0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      got = observe(); e = exp_q.pop_front(); n_assert++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL purchase[%0d] got %s want %s", i, fmt(got), fmt(e));
      end
    end
  endtask

  task automatic test_timeout();
    row_t rows[$];
    obs_t got, e;
    rows.push_back(mk(0, C100, 0, 0, 0, 0, 100, 100, 0));
    for (int k = 1; k <= 100; k++) begin
      rows.push_back(mk(0, 0, 0, 0, 0, 0, 100, 100 - k, (k == 100)));
    end
    rows.push_back(mk(0, 0, 0, 0, 0, C100, 0, 0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      got = observe(); e = exp_q.pop_front(); n_assert++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL timeout[%0d] got %s want %s", i, fmt(got), fmt(e));
      end
    end
  endtask

  task automatic test_greedy_change();
    row_t rows[$];
    obs_t got, e;
    rows.push_back(mk(0, 3'b101, 0, 0, 0, 0, 1100, 100, 0));
    rows.push_back(mk(0, C100,   0, 0, 0, 0, 1200, 100, 0));
    rows.push_back(mk(0, C100,   0, 0, 0, 0, 1300, 100, 0));
    rows.push_back(mk(0, C100,   0, 0, 0, 0, 1400, 100, 0));
    rows.push_back(mk(0, 0,      0, 1, 0, 0,      1400, 99, 1));
    rows.push_back(mk(0, 0,      0, 0, 0, C1000,   400, 99, 1));
    // Coin, selects and trigger during RETURN: coin echoed with the change.
    rows.push_back(mk(0, C500, 4'b1111, 1, 0, 3'b011, 300, 99, 1));
    rows.push_back(mk(0, 0,      0, 0, 0, C100,    200, 99, 1));
    rows.push_back(mk(0, 0,      0, 0, 0, C100,    100, 99, 1));
    rows.push_back(mk(0, 0,      0, 0, 0, C100,      0,  0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      got = observe(); e = exp_q.pop_front(); n_assert++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL greedy[%0d] got %s want %s", i, fmt(got), fmt(e));
      end
    end
  endtask

  task automatic test_ceiling();
    row_t rows[$];
    obs_t got, e;
    for (int k = 1; k <= 9; k++) begin
      rows.push_back(mk(0, C1000, 0, 0, 0, 0, 1000 * k, 100, 0));
    end
    rows.push_back(mk(0, C500,  0, 0, 0, 0,     9500, 100, 0));
    rows.push_back(mk(0, C1000, 0, 0, 0, C1000, 9500,  99, 0));
    rows.push_back(mk(0, C500,  0, 0, 0, 0,    10000, 100, 0));
    rows.push_back(mk(0, C100,  0, 0, 0, C100, 10000,  99, 0));
    rows.push_back(mk(0, 0, 4'b1000, 0, 4'b1000, 0, 8000, 100, 0));
    rows.push_back(mk(0, 0, 0, 1, 0, 0, 8000, 99, 1));
    for (int k = 1; k <= 8; k++) begin
      rows.push_back(mk(0, 0, 0, 0, 0, C1000, 8000 - 1000 * k,
                        (k < 8) ? 99 : 0, (k < 8)));
    end
    foreach (rows[i]) begin
      apply(rows[i]);
      got = observe(); e = exp_q.pop_front(); n_assert++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL ceiling[%0d] got %s want %s", i, fmt(got), fmt(e));
      end
    end
  endtask

  task automatic test_same_cycle();
    row_t rows[$];
    obs_t got, e;
    rows.push_back(mk(0, C1000, 4'b0000, 0, 4'b0000, 0, 1000, 100, 0));
    rows.push_back(mk(0, 0,     4'b0000, 0, 4'b0000, 0, 1000,  99, 0));
    rows.push_back(mk(0, C1000, 4'b1000, 0, 4'b0000, 0, 2000, 100, 0));
    rows.push_back(mk(0, C100,  4'b0001, 0, 4'b0001, 0, 1700, 100, 0));
    rows.push_back(mk(0, 0,     4'b1110, 0, 4'b0010, 0, 1200, 100, 0));
    rows.push_back(mk(0, 0,     4'b1000, 0, 4'b0000, 0, 1200,  99, 0));
    rows.push_back(mk(0, C100,  4'b0000, 1, 4'b0000, 0, 1300, 100, 1));
    rows.push_back(mk(0, 0, 0, 0, 0, C1000, 300, 100, 1));
    rows.push_back(mk(0, 0, 0, 0, 0, C100,  200, 100, 1));
    rows.push_back(mk(0, 0, 0, 0, 0, C100,  100, 100, 1));
    rows.push_back(mk(0, 0, 0, 0, 0, C100,    0,   0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      got = observe(); e = exp_q.pop_front(); n_assert++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL same_cycle[%0d] got %s want %s", i, fmt(got), fmt(e));
      end
    end
  endtask

  task automatic test_dispense_to_zero();
    row_t rows[$];
    obs_t got, e;
    rows.push_back(mk(0, C500, 4'b0000, 0, 4'b0000, 0, 500, 100, 0));
    rows.push_back(mk(0, 0,    4'b0010, 0, 4'b0010, 0,   0,   0, 0));
    rows.push_back(mk(0, 0,    4'b0001, 0, 4'b0000, 0,   0,   0, 0));
    rows.push_back(mk(0, C100, 4'b0000, 0, 4'b0000, 0, 100, 100, 0));
    rows.push_back(mk(0, 0,    4'b0001, 0, 4'b0000, 0, 100,  99, 0));
    rows.push_back(mk(0, 0,    4'b0000, 1, 4'b0000, 0, 100,  98, 1));
    rows.push_back(mk(0, 0,    4'b0000, 0, 4'b0000, C100, 0,  0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      got = observe(); e = exp_q.pop_front(); n_assert++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL dispense_zero[%0d] got %s want %s", i, fmt(got), fmt(e));
      end
    end
  endtask

  task automatic test_reset_mid_return();
    row_t rows[$];
    obs_t got, e;
    rows.push_back(mk(0, 3'b011, 0, 0, 0, 0, 600, 100, 0));
    rows.push_back(mk(0, C100,   0, 0, 0, 0, 700, 100, 0));
    rows.push_back(mk(0, 0,      0, 1, 0, 0, 700,  99, 1));
    rows.push_back(mk(1, C100,   0, 0, 0, 0,   0,   0, 0));
    rows.push_back(mk(0, 0,      0, 0, 0, 0,   0,   0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      got = observe(); e = exp_q.pop_front(); n_assert++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reset_mid_return[%0d] got %s want %s", i, fmt(got), fmt(e));
      end
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_purchase();
    test_timeout();
    test_greedy_change();
    test_ceiling();
    test_same_cycle();
    test_dispense_to_zero();
    test_reset_mid_return();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1, "time limit reached");
  end

endmodule
